// File: rtl/felica_deframer.sv
// FeliCa / NFC Type 3 deframer: hunts preamble+sync in the demodulated bit stream, assembles
// MSB-first bytes, checks the length field and CRC-16, and emits byte/frame strobes.
module felica_deframer #(
    parameter int unsigned MIN_PREAMBLE = 16,
    parameter logic [15:0] SYNC_WORD    = 16'hB24D,
    parameter logic [15:0] CRC_INIT     = 16'h0000
) (
    input  logic       adc_clk,
    input  logic       rst_n,
    input  logic       bit_in,
    input  logic       bit_stb,
    input  logic       sync_active,
    output logic [7:0] byte_out,
    output logic       byte_valid,
    output logic       frame_start,
    output logic       frame_end,
    output logic       crc_ok,
    output logic       frame_err,
    output logic       in_frame
);

    typedef enum logic [1:0] {StHunt, StLen, StData, StCrc} state_t;

    localparam logic [5:0] MinPre = 6'(MIN_PREAMBLE);

    state_t      r_state, w_state_d;
    logic [15:0] r_sreg, w_sreg_d;
    logic [5:0]  r_zrun, w_zrun_d;
    logic [15:0] r_crc, w_crc_d;
    logic [6:0]  r_acc, w_acc_d;
    logic [2:0]  r_bitcnt, w_bitcnt_d;
    logic [7:0]  r_rem, w_rem_d;
    logic [14:0] r_rx_crc, w_rx_crc_d;
    logic [3:0]  r_rxcnt, w_rxcnt_d;
    logic [7:0]  r_byte_out, w_byte_out_d;
    logic        r_byte_valid, w_byte_valid_d;
    logic        r_frame_start, w_frame_start_d;
    logic        r_frame_end, w_frame_end_d;
    logic        r_crc_ok, w_crc_ok_d;
    logic        r_frame_err, w_frame_err_d;
    logic        r_in_frame, w_in_frame_d;

    logic [15:0] w_sreg_shift;
    logic [5:0]  w_zrun_upd;
    logic [15:0] w_crc_upd;
    logic [7:0]  w_byte;

    assign w_sreg_shift = {r_sreg[14:0], bit_in};
    // zrun tracks the zero run leaving the sync window, i.e. the preamble ahead of it
    assign w_zrun_upd   = r_sreg[15] ? 6'd0 : ((r_zrun == 6'd63) ? 6'd63 : r_zrun + 6'd1);
    assign w_crc_upd    = {r_crc[14:0], 1'b0} ^ ((r_crc[15] ^ bit_in) ? 16'h1021 : 16'h0000);
    assign w_byte       = {r_acc, bit_in};

    always_comb begin
        w_state_d       = r_state;
        w_sreg_d        = r_sreg;
        w_zrun_d        = r_zrun;
        w_crc_d         = r_crc;
        w_acc_d         = r_acc;
        w_bitcnt_d      = r_bitcnt;
        w_rem_d         = r_rem;
        w_rx_crc_d      = r_rx_crc;
        w_rxcnt_d       = r_rxcnt;
        w_byte_out_d    = r_byte_out;
        w_byte_valid_d  = 1'b0;
        w_frame_start_d = 1'b0;
        w_frame_end_d   = 1'b0;
        w_crc_ok_d      = r_crc_ok;
        w_frame_err_d   = 1'b0;
        w_in_frame_d    = r_in_frame;

        if (!sync_active) begin
            // Abort wins over a coincident bit strobe; the bit is dropped.
            w_sreg_d = 16'h0000;
            w_zrun_d = 6'd0;
            if (r_state != StHunt) begin
                w_frame_err_d = 1'b1;
                w_crc_ok_d    = 1'b0;
                w_in_frame_d  = 1'b0;
                w_state_d     = StHunt;
            end
        end else if (bit_stb) begin
            unique case (r_state)
                StHunt: begin
                    w_sreg_d = w_sreg_shift;
                    w_zrun_d = w_zrun_upd;
                    if (w_sreg_shift == SYNC_WORD && w_zrun_upd >= MinPre) begin
                        w_frame_start_d = 1'b1;
                        w_in_frame_d    = 1'b1;
                        w_crc_d         = CRC_INIT;
                        w_bitcnt_d      = 3'd0;
                        w_state_d       = StLen;
                    end
                end
                StLen, StData: begin
                    w_acc_d    = w_byte[6:0];
                    w_crc_d    = w_crc_upd;
                    w_bitcnt_d = r_bitcnt + 3'd1;
                    if (r_bitcnt == 3'd7) begin
                        w_byte_out_d   = w_byte;
                        w_byte_valid_d = 1'b1;
                        if (r_state == StLen) begin
                            if (w_byte < 8'd2) begin
                                w_frame_err_d = 1'b1;
                                w_crc_ok_d    = 1'b0;
                                w_in_frame_d  = 1'b0;
                                w_state_d     = StHunt;
                            end else begin
                                w_rem_d   = w_byte - 8'd1;
                                w_state_d = StData;
                            end
                        end else begin
                            w_rem_d = r_rem - 8'd1;
                            if (r_rem == 8'd1) begin
                                w_rxcnt_d = 4'd0;
                                w_state_d = StCrc;
                            end
                        end
                    end
                end
                StCrc: begin
                    w_rx_crc_d = {r_rx_crc[13:0], bit_in};
                    w_rxcnt_d  = r_rxcnt + 4'd1;
                    if (r_rxcnt == 4'd15) begin
                        w_frame_end_d = 1'b1;
                        w_crc_ok_d    = ({r_rx_crc, bit_in} == r_crc);
                        w_in_frame_d  = 1'b0;
                        w_sreg_d      = 16'h0000;
                        w_zrun_d      = 6'd0;
                        w_state_d     = StHunt;
                    end
                end
                default: w_state_d = StHunt;
            endcase
        end
    end

    always_ff @(posedge adc_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= StHunt;
            r_sreg        <= 16'h0000;
            r_zrun        <= 6'd0;
            r_crc         <= CRC_INIT;
            r_acc         <= 7'd0;
            r_bitcnt      <= 3'd0;
            r_rem         <= 8'd0;
            r_rx_crc      <= 15'd0;
            r_rxcnt       <= 4'd0;
            r_byte_out    <= 8'd0;
            r_byte_valid  <= 1'b0;
            r_frame_start <= 1'b0;
            r_frame_end   <= 1'b0;
            r_crc_ok      <= 1'b0;
            r_frame_err   <= 1'b0;
            r_in_frame    <= 1'b0;
        end else begin
            r_state       <= w_state_d;
            r_sreg        <= w_sreg_d;
            r_zrun        <= w_zrun_d;
            r_crc         <= w_crc_d;
            r_acc         <= w_acc_d;
            r_bitcnt      <= w_bitcnt_d;
            r_rem         <= w_rem_d;
            r_rx_crc      <= w_rx_crc_d;
            r_rxcnt       <= w_rxcnt_d;
            r_byte_out    <= w_byte_out_d;
            r_byte_valid  <= w_byte_valid_d;
            r_frame_start <= w_frame_start_d;
            r_frame_end   <= w_frame_end_d;
            r_crc_ok      <= w_crc_ok_d;
            r_frame_err   <= w_frame_err_d;
            r_in_frame    <= w_in_frame_d;
        end
    end

    assign byte_out    = r_byte_out;
    assign byte_valid  = r_byte_valid;
    assign frame_start = r_frame_start;
    assign frame_end   = r_frame_end;
    assign crc_ok      = r_crc_ok;
    assign frame_err   = r_frame_err;
    assign in_frame    = r_in_frame;

endmodule

// File: tb/tb_felica_deframer.sv
// Scoreboard bench for felica_deframer: stimulus pushes expected events, a monitor pops and
// compares them whenever the DUT raises a strobe.
module tb_felica_deframer;

    localparam int EvStart = 0;
    localparam int EvByte  = 1;
    localparam int EvErr   = 2;
    localparam int EvEnd   = 3;

    typedef struct {
        int         kind;
        logic [7:0] data;
    } evt_t;

    logic       adc_clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       bit_in = 1'b0;
    logic       bit_stb = 1'b0;
    logic       sync_active = 1'b0;
    logic [7:0] byte_out;
    logic       byte_valid;
    logic       frame_start;
    logic       frame_end;
    logic       crc_ok;
    logic       frame_err;
    logic       in_frame;

    int   checks = 0;
    int   errors = 0;
    evt_t exp_q[$];

    felica_deframer dut (
        .adc_clk    (adc_clk),
        .rst_n      (rst_n),
        .bit_in     (bit_in),
        .bit_stb    (bit_stb),
        .sync_active(sync_active),
        .byte_out   (byte_out),
        .byte_valid (byte_valid),
        .frame_start(frame_start),
        .frame_end  (frame_end),
        .crc_ok     (crc_ok),
        .frame_err  (frame_err),
        .in_frame   (in_frame)
    );

    always #5 adc_clk = ~adc_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    task automatic push(input int kind, input logic [7:0] data);
        evt_t e;
        e.kind = kind;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic pop_cmp(input int kind, input logic [7:0] data);
        evt_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: got kind %0d data 0x%0h expected none", kind, data);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.data !== data) begin
                errors++;
                $display("FAIL event: got kind %0d data 0x%0h expected kind %0d data 0x%0h",
                         kind, data, e.kind, e.data);
            end
        end
    endtask

    // Monitor: fixed per-cycle order start, byte, err, end matches the push order.
    always @(negedge adc_clk) begin
        if (rst_n) begin
            if (frame_start) pop_cmp(EvStart, 8'h00);
            if (byte_valid)  pop_cmp(EvByte, byte_out);
            if (frame_err)   pop_cmp(EvErr, 8'h00);
            if (frame_end)   pop_cmp(EvEnd, {7'd0, crc_ok});
        end
    end

    function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        r = c;
        for (int i = 7; i >= 0; i--) begin
            r = (r[15] ^ b[i]) ? ({r[14:0], 1'b0} ^ 16'h1021) : {r[14:0], 1'b0};
        end
        return r;
    endfunction

    task automatic send_bit(input logic b);
        bit_in  = b;
        bit_stb = 1'b1;
        @(negedge adc_clk);
        bit_stb = 1'b0;
        repeat (3) @(negedge adc_clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
    endtask

    task automatic send_run(input int n, input logic b);
        for (int i = 0; i < n; i++) send_bit(b);
    endtask

    task automatic send_hdr(input int zeros);
        send_run(zeros, 1'b0);
        send_byte(8'hB2);
        send_byte(8'h4D);
    endtask

    task automatic nominal(input logic [7:0] last, input logic ok);
        push(EvStart, 8'h00);
        push(EvByte, 8'h02);
        push(EvByte, 8'h00);
        push(EvEnd, {7'd0, ok});
        send_hdr(48);
        send_byte(8'h02);
        send_byte(8'h00);
        send_byte(8'h66);
        send_byte(last);
    endtask

    logic [15:0] mcrc;

    initial begin
        repeat (3) @(negedge adc_clk);
        check("reset_outputs", {23'd0, byte_out, byte_valid, frame_start, frame_end, crc_ok,
                                frame_err, in_frame}, 32'd0);
        rst_n       = 1'b1;
        sync_active = 1'b1;
        repeat (2) @(negedge adc_clk);

        nominal(8'h62, 1'b1);
        repeat (4) @(negedge adc_clk);
        check("nominal_in_frame", {31'd0, in_frame}, 32'd0);
        check("nominal_crc_ok_held", {31'd0, crc_ok}, 32'd1);

        nominal(8'h63, 1'b0);
        repeat (4) @(negedge adc_clk);
        check("bad_crc_ok", {31'd0, crc_ok}, 32'd0);

        // Ones first so the zero run is genuinely only 8 long.
        send_run(16, 1'b1);
        send_hdr(8);
        send_byte(8'h02);
        send_byte(8'h00);
        send_byte(8'h66);
        send_byte(8'h62);
        check("short_pre_in_frame", {31'd0, in_frame}, 32'd0);

        nominal(8'h62, 1'b1);
        push(EvStart, 8'h00);
        push(EvByte, 8'h01);
        push(EvErr, 8'h00);
        send_hdr(48);
        send_byte(8'h01);
        check("len_err_crc_ok", {31'd0, crc_ok}, 32'd0);
        check("len_err_in_frame", {31'd0, in_frame}, 32'd0);
        nominal(8'h62, 1'b1);

        push(EvStart, 8'h00);
        push(EvByte, 8'h02);
        push(EvErr, 8'h00);
        send_hdr(48);
        send_byte(8'h02);
        check("abort_in_frame_before", {31'd0, in_frame}, 32'd1);
        send_run(4, 1'b0);
        sync_active = 1'b0;
        repeat (3) @(negedge adc_clk);
        check("abort_in_frame_after", {31'd0, in_frame}, 32'd0);
        sync_active = 1'b1;
        repeat (2) @(negedge adc_clk);

        push(EvStart, 8'h00);
        push(EvByte, 8'h02);
        send_hdr(48);
        send_byte(8'h02);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        check("pre_reset_in_frame", {31'd0, in_frame}, 32'd1);
        #1 rst_n = 1'b0;
        #1 check("async_reset_outputs", {23'd0, byte_out, byte_valid, frame_start, frame_end,
                                         crc_ok, frame_err, in_frame}, 32'd0);
        @(negedge adc_clk);
        rst_n = 1'b1;
        repeat (2) @(negedge adc_clk);

        push(EvStart, 8'h00);
        push(EvByte, 8'hFF);
        mcrc = crc_byte(16'h0000, 8'hFF);
        for (int i = 0; i < 254; i++) begin
            push(EvByte, 8'(i));
            mcrc = crc_byte(mcrc, 8'(i));
        end
        push(EvEnd, 8'h01);
        send_hdr(48);
        send_byte(8'hFF);
        for (int i = 0; i < 254; i++) send_byte(8'(i));
        send_byte(mcrc[15:8]);
        send_byte(mcrc[7:0]);
        nominal(8'h62, 1'b1);

        repeat (8) @(negedge adc_clk);
        check("pending_events", exp_q.size(), 32'd0);
        while (exp_q.size() != 0) begin
            evt_t e;
            e = exp_q.pop_front();
            $display("FAIL missing_event: got none expected kind %0d data 0x%0h", e.kind, e.data);
            errors++;
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/felica_deframer.md
Name: felica_deframer

Overview:
- Downstream consumer of the 212/424 kbit ISO/IEC 18092 (FeliCa / NFC Type 3) demodulator.
- Takes the demodulator's polarity-corrected bit stream, one strobe per recovered bit, and hunts for preamble plus sync.
- Assembles the bytes that follow the sync (MSB first), checks the length field and the CRC-16, and presents bytes, frame-boundary strobes and a CRC verdict.
- Its outputs feed the ARM-side capture path, so the ARM no longer has to search the raw bit stream.

Parameters:
MIN_PREAMBLE, 16, minimum run of consecutive 0 bits required immediately before the sync word (1..63)
SYNC_WORD, 16'hB24D, sync pattern, received MSB first
CRC_INIT, 16'h0000, CRC-16 preset (polynomial 0x1021, no reflection, no final XOR)

Ports:
adc_clk  in  1  clock; same domain as the demodulator
rst_n  in  1  asynchronous active-low reset
bit_in  in  1  decoded data bit; valid when bit_stb=1
bit_stb  in  1  one-cycle strobe, one per recovered bit (at most one per 32 cycles)
sync_active  in  1  demodulator locked to a modulated signal; 0 means carrier is idle or desynced
byte_out  out  8  assembled byte (length byte and payload; CRC bytes excluded)
byte_valid  out  1  one-cycle strobe; byte_out is valid in that cycle
frame_start  out  1  one-cycle strobe in the cycle after the last sync bit is accepted
frame_end  out  1  one-cycle strobe after the second CRC byte completes
crc_ok  out  1  valid with frame_end; 1 when the received CRC equals the computed CRC
frame_err  out  1  one-cycle strobe on a length error or an abort
in_frame  out  1  level; high from frame_start until frame_end or frame_err

Behaviour:
- Reset: state=HUNT; shift register=0; zero-run counter=0; CRC=CRC_INIT; byte_out=0; all strobes=0; crc_ok=0; in_frame=0.
- All outputs are registered. All activity advances only on cycles with bit_stb=1, except aborts.
- HUNT:
  - 16-bit shift register sreg <= {sreg[14:0], bit_in}.
  - 6-bit zrun counts consecutive 0 bits leaving sreg[15], saturating at 63; a 1 leaving sreg[15] clears it.
  - Match when the updated sreg==SYNC_WORD and zrun>=MIN_PREAMBLE. On a match: frame_start=1 next cycle, CRC<=CRC_INIT, bitcnt<=0, go to LEN.
- Bit assembly (LEN, DATA, CRC states): shift MSB first into an 8-bit accumulator; a byte is complete when 3-bit bitcnt wraps 7->0.
- CRC update per data bit (LEN and DATA states only): crc <= {crc[14:0],1'b0} ^ ((crc[15]^bit_in) ? 16'h1021 : 0).
- LEN:
  - On byte completion, emit byte_valid with the byte (latency: 1 cycle after the 8th bit_stb). Store L.
  - If L<2: frame_err, go to HUNT; the byte is still emitted.
  - Otherwise remaining <= L-1 and go to DATA.
- DATA: on each byte completion, emit byte_valid and decrement remaining. When remaining reaches 0, go to CRC with the CRC register frozen.
- CRC: shift 16 received bits into rx_crc. After the 16th bit: frame_end=1; crc_ok=(rx_crc==crc); in_frame=0; go to HUNT with sreg=0 and zrun=0. crc_ok holds until the next frame_end, frame_err or reset.
- Abort:
  - sync_active=0 in any state other than HUNT → frame_err next cycle, in_frame=0, go to HUNT, clear sreg and zrun; no frame_end.
  - Abort takes priority over a bit_stb in the same cycle; that bit is discarded.
  - In HUNT, sync_active=0 clears sreg and zrun.
- frame_err clears crc_ok.
- Back-to-back frames are legal: hunting resumes on the first bit_stb after frame_end.
- Maximum frame: L=255 gives 254 payload bytes. remaining is 8 bits and never underflows.

Test Plan:
- Nominal frame: 48×0, B24D, bytes 02 00 66 62, sync_active=1 → frame_start once; byte_valid ×2 with 0x02 then 0x00; frame_end with crc_ok=1; no frame_err.
- Corrupted CRC: same as nominal with last byte 0x63 → frame_end with crc_ok=0; 2 bytes emitted.
- Short preamble: 8×0 then B24D 02 00 66 62 (MIN_PREAMBLE=16) → no frame_start, no byte_valid; stays in HUNT.
- Length error: 48×0, B24D, 0x01 → byte_valid 0x01 followed by frame_err; next valid frame decodes normally.
- Abort and reset: drop sync_active after 4 bits of the payload byte → frame_err, in_frame=0, no frame_end. Assert rst_n=0 mid-payload → all outputs 0 immediately (asynchronously).
- Back-to-back at max length: frame with L=0xFF (254 payload bytes plus correct CRC from a model), then the nominal frame with no idle gap → 255 and 2 byte_valids respectively; two frame_end, both crc_ok=1.
